// File: rtl/axi_cdc_dst.sv
// axi_cdc_dst: destination half of a split AXI CDC; pops AW/W/AR and pushes B/R through inline gray-pointer FIFOs.
// Define AXI_CDC_DST_ISOLATE_EN to add isolate_i/isolated_o with outstanding-transaction tracking.
package axi_cdc_dst_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ax_chan_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;
  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;
  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } axi_resp_t;
endpackage

module axi_cdc_dst #(
  parameter int unsigned LogDepth   = 1,
  parameter int unsigned SyncStages = 2,
  parameter type aw_chan_t  = axi_cdc_dst_pkg::ax_chan_t,
  parameter type w_chan_t   = axi_cdc_dst_pkg::w_chan_t,
  parameter type b_chan_t   = axi_cdc_dst_pkg::b_chan_t,
  parameter type ar_chan_t  = axi_cdc_dst_pkg::ax_chan_t,
  parameter type r_chan_t   = axi_cdc_dst_pkg::r_chan_t,
  parameter type axi_req_t  = axi_cdc_dst_pkg::axi_req_t,
  parameter type axi_resp_t = axi_cdc_dst_pkg::axi_resp_t
) (
  input  logic                               dst_clk_i,
  input  logic                               dst_rst_ni,
  output axi_req_t                           dst_req_o,
  input  axi_resp_t                          dst_resp_i,
`ifdef AXI_CDC_DST_ISOLATE_EN
  input  logic                               isolate_i,
  output logic                               isolated_o,
`endif
  input  logic [LogDepth:0]                  async_data_slave_aw_wptr_i,
  output logic [LogDepth:0]                  async_data_slave_aw_rptr_o,
  input  aw_chan_t [2**LogDepth-1:0]         async_data_slave_aw_data_i,
  input  logic [LogDepth:0]                  async_data_slave_w_wptr_i,
  output logic [LogDepth:0]                  async_data_slave_w_rptr_o,
  input  w_chan_t [2**LogDepth-1:0]          async_data_slave_w_data_i,
  input  logic [LogDepth:0]                  async_data_slave_ar_wptr_i,
  output logic [LogDepth:0]                  async_data_slave_ar_rptr_o,
  input  ar_chan_t [2**LogDepth-1:0]         async_data_slave_ar_data_i,
  output logic [LogDepth:0]                  async_data_slave_b_wptr_o,
  input  logic [LogDepth:0]                  async_data_slave_b_rptr_i,
  output b_chan_t [2**LogDepth-1:0]          async_data_slave_b_data_o,
  output logic [LogDepth:0]                  async_data_slave_r_wptr_o,
  input  logic [LogDepth:0]                  async_data_slave_r_rptr_i,
  output r_chan_t [2**LogDepth-1:0]          async_data_slave_r_data_o
);
  localparam int unsigned PtrW = LogDepth + 1;
  typedef logic [PtrW-1:0] ptr_t;
  // Full when the write pointer is one lap ahead: top two gray bits inverted.
  localparam ptr_t FullMask = ptr_t'(3) << (LogDepth - 1);

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  logic iso_gate;
  ptr_t pop_wptr [3];
  ptr_t pop_rptr [3];
  logic [LogDepth-1:0] pop_idx [3];
  logic [2:0] pop_empty, pop_valid, pop_fire;
  ptr_t push_rptr [2];
  ptr_t push_wptr [2];
  logic [LogDepth-1:0] push_idx [2];
  logic [1:0] push_full, push_fire;
  b_chan_t [2**LogDepth-1:0] b_mem_q;
  r_chan_t [2**LogDepth-1:0] r_mem_q;

  assign pop_wptr[0] = async_data_slave_aw_wptr_i;
  assign pop_wptr[1] = async_data_slave_w_wptr_i;
  assign pop_wptr[2] = async_data_slave_ar_wptr_i;
  assign async_data_slave_aw_rptr_o = pop_rptr[0];
  assign async_data_slave_w_rptr_o  = pop_rptr[1];
  assign async_data_slave_ar_rptr_o = pop_rptr[2];
  assign push_rptr[0] = async_data_slave_b_rptr_i;
  assign push_rptr[1] = async_data_slave_r_rptr_i;
  assign async_data_slave_b_wptr_o = push_wptr[0];
  assign async_data_slave_r_wptr_o = push_wptr[1];
  assign async_data_slave_b_data_o = b_mem_q;
  assign async_data_slave_r_data_o = r_mem_q;

  for (genvar c = 0; c < 3; c++) begin : g_pop
    ptr_t sync_q [SyncStages];
    ptr_t bin_q, gray_q;
    always_ff @(posedge dst_clk_i or negedge dst_rst_ni) begin
      if (!dst_rst_ni) begin
        sync_q <= '{default: '0};
        bin_q  <= '0;
        gray_q <= '0;
      end else begin
        sync_q[0] <= pop_wptr[c];
        for (int i = 1; i < SyncStages; i++) sync_q[i] <= sync_q[i-1];
        if (pop_fire[c]) begin
          bin_q  <= bin_q + ptr_t'(1);
          gray_q <= bin2gray(bin_q + ptr_t'(1));
        end
      end
    end
    assign pop_empty[c] = gray_q == sync_q[SyncStages-1];
    assign pop_rptr[c]  = gray_q;
    assign pop_idx[c]   = bin_q[LogDepth-1:0];
  end

  for (genvar c = 0; c < 2; c++) begin : g_push
    ptr_t sync_q [SyncStages];
    ptr_t bin_q, gray_q;
    always_ff @(posedge dst_clk_i or negedge dst_rst_ni) begin
      if (!dst_rst_ni) begin
        sync_q <= '{default: '0};
        bin_q  <= '0;
        gray_q <= '0;
      end else begin
        sync_q[0] <= push_rptr[c];
        for (int i = 1; i < SyncStages; i++) sync_q[i] <= sync_q[i-1];
        if (push_fire[c]) begin
          bin_q  <= bin_q + ptr_t'(1);
          gray_q <= bin2gray(bin_q + ptr_t'(1));
        end
      end
    end
    assign push_full[c] = gray_q == (sync_q[SyncStages-1] ^ FullMask);
    assign push_wptr[c] = gray_q;
    assign push_idx[c]  = bin_q[LogDepth-1:0];
  end

  assign pop_valid = ~pop_empty & {~iso_gate, 1'b1, ~iso_gate};
  assign pop_fire  = pop_valid & {dst_resp_i.ar_ready, dst_resp_i.w_ready, dst_resp_i.aw_ready};
  assign push_fire = ~push_full & {dst_resp_i.r_valid, dst_resp_i.b_valid};

  always_ff @(posedge dst_clk_i or negedge dst_rst_ni) begin
    if (!dst_rst_ni) begin
      b_mem_q <= '0;
      r_mem_q <= '0;
    end else begin
      if (push_fire[0]) b_mem_q[push_idx[0]] <= dst_resp_i.b;
      if (push_fire[1]) r_mem_q[push_idx[1]] <= dst_resp_i.r;
    end
  end

`ifdef AXI_CDC_DST_ISOLATE_EN
  logic [7:0] wr_cnt_q, rd_cnt_q;

  function automatic logic [7:0] sat_step(input logic [7:0] cnt, input logic inc, input logic dec);
    return (inc && !dec && cnt != 8'hff) ? cnt + 8'd1 :
           (dec && !inc && cnt != 8'h00) ? cnt - 8'd1 : cnt;
  endfunction

  always_ff @(posedge dst_clk_i or negedge dst_rst_ni) begin
    if (!dst_rst_ni) begin
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      isolated_o <= 1'b0;
    end else begin
      wr_cnt_q   <= sat_step(wr_cnt_q, pop_fire[0], push_fire[0]);
      rd_cnt_q   <= sat_step(rd_cnt_q, pop_fire[2], push_fire[1] && dst_resp_i.r.last);
      isolated_o <= isolate_i && wr_cnt_q == 8'd0 && rd_cnt_q == 8'd0;
    end
  end

  assign iso_gate = isolate_i;
`else
  assign iso_gate = 1'b0;
`endif

  always_comb begin
    dst_req_o          = '0;
    dst_req_o.aw       = async_data_slave_aw_data_i[pop_idx[0]];
    dst_req_o.aw_valid = pop_valid[0];
    dst_req_o.w        = async_data_slave_w_data_i[pop_idx[1]];
    dst_req_o.w_valid  = pop_valid[1];
    dst_req_o.ar       = async_data_slave_ar_data_i[pop_idx[2]];
    dst_req_o.ar_valid = pop_valid[2];
    dst_req_o.b_ready  = ~push_full[0];
    dst_req_o.r_ready  = ~push_full[1];
  end
endmodule

// File: tb/tb_axi_cdc_dst.sv
// tb_axi_cdc_dst: directed and randomized checks of axi_cdc_dst; the bench plays the source half
// and tracks expected beats with queues and gray/binary pointer arithmetic.
`timescale 1ns/1ps
module tb_axi_cdc_dst;
  import axi_cdc_dst_pkg::*;
  localparam int LogDepth = 1, SyncStages = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_req_t req;
  axi_resp_t resp;
  logic [1:0] aw_wptr, w_wptr, ar_wptr, aw_rptr, w_rptr, ar_rptr, b_wptr, r_wptr, b_rptr, r_rptr;
  ax_chan_t [1:0] aw_mem, ar_mem;
  w_chan_t [1:0] w_mem;
  b_chan_t [1:0] b_mem;
  r_chan_t [1:0] r_mem;
`ifdef AXI_CDC_DST_ISOLATE_EN
  logic isolate = 1'b0, isolated;
`endif

  axi_cdc_dst #(.LogDepth(LogDepth), .SyncStages(SyncStages)) dut (
    .dst_clk_i(clk),
    .dst_rst_ni(rst_n),
    .dst_req_o(req),
    .dst_resp_i(resp),
`ifdef AXI_CDC_DST_ISOLATE_EN
    .isolate_i(isolate),
    .isolated_o(isolated),
`endif
    .async_data_slave_aw_wptr_i(aw_wptr),
    .async_data_slave_aw_rptr_o(aw_rptr),
    .async_data_slave_aw_data_i(aw_mem),
    .async_data_slave_w_wptr_i(w_wptr),
    .async_data_slave_w_rptr_o(w_rptr),
    .async_data_slave_w_data_i(w_mem),
    .async_data_slave_ar_wptr_i(ar_wptr),
    .async_data_slave_ar_rptr_o(ar_rptr),
    .async_data_slave_ar_data_i(ar_mem),
    .async_data_slave_b_wptr_o(b_wptr),
    .async_data_slave_b_rptr_i(b_rptr),
    .async_data_slave_b_data_o(b_mem),
    .async_data_slave_r_wptr_o(r_wptr),
    .async_data_slave_r_rptr_i(r_rptr),
    .async_data_slave_r_data_o(r_mem)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] gray(input int n);
    logic [1:0] b;
    b = 2'(n);
    return b ^ (b >> 1);
  endfunction

  function automatic int ungray(input logic [1:0] g);
    for (int i = 0; i < 4; i++) if (gray(i) == g) return i;
    return 0;
  endfunction

  task automatic clear_source();
    resp = '0;
    {aw_wptr, w_wptr, ar_wptr, b_rptr, r_rptr} = '0;
    aw_mem = '0;
    ar_mem = '0;
    w_mem  = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    r_chan_t r_q[$];
    w_chan_t w_q[$];
    r_chan_t rb;
    w_chan_t wb, w_exp;
    logic [1:0] used;
    int r_pushed = 0, r_popped = 0, w_pushed = 0, w_popped = 0;
    clear_source();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_aw_valid", 64'(req.aw_valid), 64'd0);
    chk("rst_w_valid", 64'(req.w_valid), 64'd0);
    chk("rst_ar_valid", 64'(req.ar_valid), 64'd0);
    chk("rst_b_ready", 64'(req.b_ready), 64'd1);
    chk("rst_r_ready", 64'(req.r_ready), 64'd1);
    chk("rst_ptrs", 64'({aw_rptr, w_rptr, ar_rptr, b_wptr, r_wptr}), 64'd0);

    aw_mem[0] = '{id: 4'd1, addr: 32'hA5, len: 8'd0};
    aw_wptr = gray(1);
    step();
    chk("aw_valid_edge1", 64'(req.aw_valid), 64'd0);
    step();
    chk("aw_valid_edge2", 64'(req.aw_valid), 64'd1);
    chk("aw_addr", 64'(req.aw.addr), 64'hA5);
    resp.aw_ready = 1'b1;
    step();
    chk("aw_rptr_pop", 64'(aw_rptr), 64'd1);
    chk("aw_valid_after_pop", 64'(req.aw_valid), 64'd0);
    resp.aw_ready = 1'b0;

    resp.b_valid = 1'b1;
    resp.b = '{id: 4'd3, resp: 2'd0};
    step();
    chk("b_wptr_1", 64'(b_wptr), 64'd1);
    chk("b_data0", 64'(b_mem[0].id), 64'd3);
    chk("b_ready_1", 64'(req.b_ready), 64'd1);
    resp.b.id = 4'd4;
    step();
    chk("b_wptr_2", 64'(b_wptr), 64'd3);
    chk("b_data1", 64'(b_mem[1].id), 64'd4);
    chk("b_ready_full", 64'(req.b_ready), 64'd0);
    resp.b.id = 4'd5;
    step();
    chk("b_wptr_held", 64'(b_wptr), 64'd3);
    chk("b_data0_held", 64'(b_mem[0].id), 64'd3);
    resp.b_valid = 1'b0;
    b_rptr = gray(1);
    step();
    chk("b_ready_sync1", 64'(req.b_ready), 64'd0);
    step();
    chk("b_ready_sync2", 64'(req.b_ready), 64'd1);

    for (int cyc = 0; cyc < 3000 && !(r_popped >= 40 && w_popped >= 24); cyc++) begin
      @(negedge clk);
      chk("r_wptr_seq", 64'(r_wptr), 64'(gray(r_pushed)));
      rb.id = 4'($urandom);
      rb.data = $urandom;
      rb.resp = 2'($urandom);
      rb.last = 1'($urandom);
      resp.r = rb;
      resp.r_valid = $urandom_range(0, 3) != 0;
      if (resp.r_valid && req.r_ready) begin
        r_q.push_back(rb);
        r_pushed++;
      end
      if (2'(ungray(r_wptr) - r_popped) != 2'd0 && $urandom_range(0, 1) == 1) begin
        chk("r_data_order", 64'(r_mem[1'(r_popped)]), 64'(r_q.pop_front()));
        r_popped++;
        r_rptr = gray(r_popped);
      end
      resp.w_ready = $urandom_range(0, 1) == 1;
      if (req.w_valid && resp.w_ready) begin
        w_exp = w_q.size() != 0 ? w_q.pop_front() : 'x;
        chk("w_data_order", 64'(req.w), 64'(w_exp));
        w_popped++;
      end
      used = 2'(w_pushed - ungray(w_rptr));
      if (used < 2'd2 && $urandom_range(0, 2) != 0) begin
        wb.data = $urandom;
        wb.strb = 4'($urandom);
        wb.last = 1'($urandom);
        w_mem[1'(w_pushed)] = wb;
        w_q.push_back(wb);
        w_pushed++;
        w_wptr = gray(w_pushed);
      end
    end
    chk("stream_done", 64'(r_popped >= 40 && w_popped >= 24), 64'd1);

    @(negedge clk);
    resp = '0;
    if (2'(w_pushed - ungray(w_rptr)) == 2'd0) begin
      w_mem[1'(w_pushed)] = '{data: 32'h1234, strb: 4'hf, last: 1'b1};
      w_pushed++;
      w_wptr = gray(w_pushed);
    end
    repeat (3) step();
    chk("w_valid_prereset", 64'(req.w_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    clear_source();
    #1;
    chk("midrst_w_valid", 64'(req.w_valid), 64'd0);
    chk("midrst_ptrs", 64'({aw_rptr, w_rptr, ar_rptr, b_wptr, r_wptr}), 64'd0);
    chk("midrst_readies", 64'({req.b_ready, req.r_ready}), 64'd3);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef AXI_CDC_DST_ISOLATE_EN
    ar_mem[0] = '{id: 4'd1, addr: 32'h100, len: 8'd0};
    ar_mem[1] = '{id: 4'd2, addr: 32'h200, len: 8'd0};
    ar_wptr = gray(2);
    resp.ar_ready = 1'b1;
    repeat (5) step();
    chk("iso_ar_popped", 64'(ar_rptr), 64'(gray(2)));
    isolate = 1'b1;
    ar_mem[0] = '{id: 4'd3, addr: 32'h300, len: 8'd0};
    ar_wptr = gray(3);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("iso_ar_gated", 64'(req.ar_valid), 64'd0);
      chk("iso_not_done", 64'(isolated), 64'd0);
    end
    resp.r_valid = 1'b1;
    resp.r = '{id: 4'd1, data: 32'h0, resp: 2'd0, last: 1'b1};
    step();
    resp.r.id = 4'd2;
    step();
    resp.r_valid = 1'b0;
    chk("iso_before_edge", 64'(isolated), 64'd0);
    step();
    chk("iso_done", 64'(isolated), 64'd1);
    chk("iso_ar_still_gated", 64'(req.ar_valid), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
